localizer_scheduler: RTL and testbench
======================================

Name: localizer_scheduler

Overview:
- Sits between the FFT output stream and the localizer datapath.
- Frames the per-bin 4-mic FFT stream and forwards only bins inside a programmable frequency band. Out-of-band bins are consumed and dropped.
- Buffers forwarded bins in a small FIFO against localizer backpressure.
- Sequences frames: enable, stream, drain, done pulse. Reports frame count, forwarded-bin count and frame-length errors.

Parameters:
- N_BINS, 1024, FFT bins per frame.
- BIN_W, 10, bin index width; must equal clog2(N_BINS).
- FIFO_DEPTH, 4, forwarding FIFO entries; power of 2, at least 2.

Ports:
- clk_in  input  1  system clock
- rst_n_in  input  1  reset; asynchronous, active-low
- enable_in  input  1  run request; sampled in IDLE and at frame end
- bin_lo_in  input  BIN_W  first in-band bin, inclusive
- bin_hi_in  input  BIN_W  last in-band bin, inclusive
- fft_data_in  input  128  bin data, mic0 in [31:0] through mic3 in [127:96]; each 32-bit word is {im[31:16], re[15:0]}
- fft_valid_in  input  1  FFT beat valid
- fft_last_in  input  1  last beat of frame
- fft_ready_out  output  1  scheduler accepts beat
- loc_data_out  output  128  bin data to localizer
- loc_valid_out  output  1  loc_data_out valid
- loc_ready_in  input  1  localizer ready
- frame_active_out  output  1  high in ACTIVE or DRAIN
- frame_done_out  output  1  one-cycle pulse at frame completion
- frame_count_out  output  16  completed frames, wraps
- bins_sent_out  output  BIN_W+1  bins forwarded in the last completed frame
- length_error_out  output  1  sticky; frame length differed from N_BINS

Behaviour:
- Reset (async assert, sync deassert internally):
  - State goes to IDLE; FIFO empties; bin counter is 0.
  - All outputs are 0, including loc_data_out.
- Beat transfer:
  - A beat transfers when fft_valid_in and fft_ready_out are both high.
  - A loc transfer happens when loc_valid_out and loc_ready_in are both high.
- Band handling:
  - bin_lo/bin_hi are latched on IDLE→ACTIVE and on DRAIN→ACTIVE.
  - Mid-frame input changes are ignored.
  - A beat is in band when lo_q ≤ bin_cnt ≤ hi_q. If lo_q > hi_q, the band is empty: all beats are dropped and the frame still completes.
- fft_ready_out:
  - ACTIVE: (bin out of band) OR (FIFO not full).
  - IDLE and DRAIN: 0.
  - Depends only on registered state, bin_cnt and FIFO count. It never depends on fft_valid_in.
- FIFO:
  - In-band accepted beats are written.
  - loc_valid_out = FIFO not empty; loc_data_out = FIFO head. First-word fall-through: a write to an empty FIFO is visible on the next cycle.
  - A simultaneous write and read when full is not possible, because ready is low when full.
  - Simultaneous write and read otherwise leaves the count unchanged.
- Bin counter:
  - Increments on each accepted beat; returns to 0 after an accepted beat with fft_last_in.
  - Saturates at N_BINS-1 if tlast is late; extra beats are treated as bin N_BINS-1.
- Per-frame sent counter: increments on each FIFO write and clears at ACTIVE entry.
- FSM:
  - IDLE → ACTIVE when enable_in = 1.
  - ACTIVE → DRAIN on an accepted beat with fft_last_in.
  - Length check on that beat: set length_error_out if bin_cnt ≠ N_BINS-1, or if extra beats arrived beyond N_BINS-1.
  - DRAIN → completion when the FIFO is empty and no read is pending:
    - pulse frame_done_out;
    - frame_count_out += 1, wrapping 0xFFFF→0;
    - bins_sent_out ← sent counter;
    - next state ACTIVE if enable_in, else IDLE.
- enable_in dropping mid-frame: the current frame finishes normally, then the FSM goes to IDLE.
- length_error_out clears only on reset.
- Latency: in-band beat accepted at cycle t → loc_valid_out at t+1 if the FIFO was empty.
- Minimum frame gap: DRAIN lasts at least 1 cycle. If the FIFO is empty at tlast, frame_done_out pulses at t+1 and ready returns at t+2.

Test Plan:
- Reset release, enable=1, lo=10, hi=13, 1024-beat frame with data = bin index, loc_ready=1 → exactly bins 10..13 on loc_data_out in order. frame_done_out pulses once; frame_count=1; bins_sent=4; length_error=0.
- Same frame with loc_ready held 0 → FIFO fills with bins 10..13 (depth 4) and fft_ready stays 1 for out-of-band bins. After tlast, state holds DRAIN. Raising loc_ready drains 4 beats, then done pulses.
- lo=20, hi=5 → no loc_valid for the whole frame; done pulses; bins_sent=0.
- tlast on beat 600 → length_error=1 (sticky), frame_count increments. The next frame starts at bin 0 and forwards correctly.
- enable dropped at bin 300 → the frame completes and the FSM returns to IDLE. fft_ready stays 0 until enable reasserts.
- rst_n_in asserted mid-frame with the FIFO holding 2 entries → all outputs 0 immediately; the FIFO is empty after release; frame_count=0.

Source files
------------

// File: rtl/localizer_scheduler_if.sv
// Stream bundle between the FFT source, the scheduler and the localizer.
// The master side drives FFT beats and localizer ready; the slave side is the scheduler.
interface localizer_scheduler_if;
    logic [127:0] fft_data_in;
    logic         fft_valid_in;
    logic         fft_last_in;
    logic         fft_ready_out;
    logic [127:0] loc_data_out;
    logic         loc_valid_out;
    logic         loc_ready_in;

    modport master (
        output fft_data_in, fft_valid_in, fft_last_in, loc_ready_in,
        input  fft_ready_out, loc_data_out, loc_valid_out
    );

    modport slave (
        input  fft_data_in, fft_valid_in, fft_last_in, loc_ready_in,
        output fft_ready_out, loc_data_out, loc_valid_out
    );
endinterface

// File: rtl/localizer_scheduler.sv
// Frames the per-bin 4-mic FFT stream, forwards in-band bins through a small
// first-word-fall-through FIFO to the localizer, and sequences frames
// (IDLE -> ACTIVE -> DRAIN -> done) with frame/bin/length bookkeeping.
module localizer_scheduler #(
    parameter int N_BINS     = 1024,
    parameter int BIN_W      = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  enable_in,
    input  logic [BIN_W-1:0]      bin_lo_in,
    input  logic [BIN_W-1:0]      bin_hi_in,
    localizer_scheduler_if.slave  bus,
    output logic                  frame_active_out,
    output logic                  frame_done_out,
    output logic [15:0]           frame_count_out,
    output logic [BIN_W:0]        bins_sent_out,
    output logic                  length_error_out
);
    localparam int DATA_W = 128;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(N_BINS - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DRAIN} state_t;

    state_t             state;
    logic               rst_sync_p0, rst_n;
    logic [BIN_W-1:0]   lo_q, hi_q, bin_cnt;
    logic               over_q;
    logic [BIN_W:0]     sent_cnt;
    logic [DATA_W-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   fifo_cnt;
    logic               in_band, fifo_full, fifo_empty, beat, wr_en, rd_en;

    // Reset synchronizer: assertion is immediate, release is aligned to clk_in.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rst_sync_p0 <= 1'b0;
            rst_n       <= 1'b0;
        end else begin
            rst_sync_p0 <= 1'b1;
            rst_n       <= rst_sync_p0;
        end
    end

    assign in_band    = (lo_q <= bin_cnt) && (bin_cnt <= hi_q);
    assign fifo_full  = (fifo_cnt == FULL_CNT);
    assign fifo_empty = (fifo_cnt == '0);

    // Ready comes only from registered state so it never loops back on valid.
    assign bus.fft_ready_out = (state == S_ACTIVE) && (!in_band || !fifo_full);
    assign beat  = bus.fft_valid_in && bus.fft_ready_out;
    assign wr_en = beat && in_band;
    assign rd_en = bus.loc_valid_out && bus.loc_ready_in;

    assign bus.loc_valid_out = !fifo_empty;
    // Storage is not reset, so the head is masked to keep the output at zero while empty.
    assign bus.loc_data_out  = fifo_empty ? '0 : mem[rd_ptr];

    assign frame_active_out = (state == S_ACTIVE) || (state == S_DRAIN);
    // DRAIN only sees reads, so an empty FIFO here means the frame is fully delivered.
    assign frame_done_out   = (state == S_DRAIN) && fifo_empty;

    // FIFO storage write; data path carries no reset.
    always_ff @(posedge clk_in) begin
        if (wr_en) mem[wr_ptr] <= bus.fft_data_in;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Frame sequencer: band latch, bin counting, length check and completion stats.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            lo_q             <= '0;
            hi_q             <= '0;
            bin_cnt          <= '0;
            over_q           <= 1'b0;
            sent_cnt         <= '0;
            frame_count_out  <= '0;
            bins_sent_out    <= '0;
            length_error_out <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (enable_in) begin
                        state    <= S_ACTIVE;
                        lo_q     <= bin_lo_in;
                        hi_q     <= bin_hi_in;
                        sent_cnt <= '0;
                    end
                end
                S_ACTIVE: begin
                    if (wr_en) sent_cnt <= sent_cnt + 1'b1;
                    if (beat) begin
                        if (bus.fft_last_in) begin
                            state   <= S_DRAIN;
                            bin_cnt <= '0;
                            over_q  <= 1'b0;
                            if ((bin_cnt != LAST_BIN) || over_q) length_error_out <= 1'b1;
                        end else if (bin_cnt == LAST_BIN) begin
                            // Late tlast: hold at the last bin and remember the overrun.
                            over_q <= 1'b1;
                        end else begin
                            bin_cnt <= bin_cnt + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (fifo_empty) begin
                        frame_count_out <= frame_count_out + 16'd1;
                        bins_sent_out   <= sent_cnt;
                        if (enable_in) begin
                            state    <= S_ACTIVE;
                            lo_q     <= bin_lo_in;
                            hi_q     <= bin_hi_in;
                            sent_cnt <= '0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_localizer_scheduler.sv
// Directed bench for localizer_scheduler: band pass, backpressure, empty band,
// short/long frames, enable drop and mid-frame reset.
module tb_localizer_scheduler;
    localparam int BIN_W = 10;

    logic              clk_in = 1'b0;
    logic              rst_n_in = 1'b0;
    logic              enable_in = 1'b0;
    logic [BIN_W-1:0]  bin_lo_in = '0;
    logic [BIN_W-1:0]  bin_hi_in = '0;
    logic              frame_active_out, frame_done_out, length_error_out;
    logic [15:0]       frame_count_out;
    logic [BIN_W:0]    bins_sent_out;

    localizer_scheduler_if bus();

    localizer_scheduler #(.N_BINS(1024), .BIN_W(BIN_W), .FIFO_DEPTH(4)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .enable_in(enable_in),
        .bin_lo_in(bin_lo_in), .bin_hi_in(bin_hi_in), .bus(bus),
        .frame_active_out(frame_active_out), .frame_done_out(frame_done_out),
        .frame_count_out(frame_count_out), .bins_sent_out(bins_sent_out),
        .length_error_out(length_error_out)
    );

    always #5 clk_in = ~clk_in;

    int compared = 0;
    int failed   = 0;
    logic [127:0] rx_q[$];
    int done_total  = 0;
    int valid_total = 0;

    // Observer: records localizer transfers and done pulses away from the active edge.
    always @(negedge clk_in) begin
        if (bus.loc_valid_out === 1'b1 && bus.loc_ready_in === 1'b1) rx_q.push_back(bus.loc_data_out);
        if (bus.loc_valid_out === 1'b1) valid_total++;
        if (frame_done_out === 1'b1) done_total++;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [127:0] mk(input int i);
        logic [31:0] b;
        b = 32'(i);
        return {32'h3000_0000 | b, 32'h2000_0000 | b, 32'h1000_0000 | b, b};
    endfunction

    function automatic logic [127:0] rx_at(input int idx);
        if (idx < rx_q.size()) return rx_q[idx];
        return 'x;
    endfunction

    task automatic sync();
        @(posedge clk_in); #1;
    endtask

    task automatic send_beats(input int from, input int to, input int last_at,
                              output int stalls, output bit tmo);
        stalls = 0;
        tmo = 1'b0;
        sync();
        for (int i = from; i <= to; i++) begin
            int w;
            w = 0;
            bus.fft_data_in  = mk(i);
            bus.fft_valid_in = 1'b1;
            bus.fft_last_in  = (i == last_at);
            @(negedge clk_in);
            while (bus.fft_ready_out !== 1'b1 && w < 50) begin
                @(negedge clk_in);
                w++;
            end
            if (w >= 50) begin
                tmo = 1'b1;
                bus.fft_valid_in = 1'b0;
                bus.fft_last_in  = 1'b0;
                return;
            end
            stalls += w;
            @(posedge clk_in); #1;
        end
        bus.fft_valid_in = 1'b0;
        bus.fft_last_in  = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int n;
        n = 0;
        while (done_total < target && n < 40) begin
            @(negedge clk_in);
            n++;
        end
        sync();
    endtask

    task automatic test_reset();
        rst_n_in = 1'b0;
        bus.fft_valid_in = 1'b0; bus.fft_last_in = 1'b0; bus.fft_data_in = '0; bus.loc_ready_in = 1'b0;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        compared++;
        if (bus.loc_valid_out !== 1'b0 || bus.loc_data_out !== '0 || bus.fft_ready_out !== 1'b0) begin
            failed++; $display("FAIL reset_stream: valid=%b data=%h ready=%b want 0/0/0",
                               bus.loc_valid_out, bus.loc_data_out, bus.fft_ready_out);
        end
        compared++;
        if (frame_active_out !== 1'b0 || frame_done_out !== 1'b0 || frame_count_out !== 16'd0 ||
            bins_sent_out !== '0 || length_error_out !== 1'b0) begin
            failed++; $display("FAIL reset_status: act=%b done=%b cnt=%0d sent=%0d err=%b want all 0",
                               frame_active_out, frame_done_out, frame_count_out, bins_sent_out, length_error_out);
        end
        sync();
        rst_n_in = 1'b1;
        repeat (3) sync();
        compared++;
        if (bus.fft_ready_out !== 1'b0 || frame_active_out !== 1'b0) begin
            failed++; $display("FAIL reset_idle: ready=%b act=%b want 0/0", bus.fft_ready_out, frame_active_out);
        end
    endtask

    task automatic test_band_pass();
        int base, d0, st; bit tmo;
        base = rx_q.size(); d0 = done_total;
        bin_lo_in = 10; bin_hi_in = 13; bus.loc_ready_in = 1'b1; enable_in = 1'b1;
        send_beats(0, 1023, 1023, st, tmo);
        enable_in = 1'b0;
        compared++;
        if (tmo) begin failed++; $display("FAIL band_pass_accept: got timeout want all beats accepted"); end
        wait_done(d0 + 1);
        compared++;
        if (rx_q.size() - base !== 4) begin failed++; $display("FAIL band_pass_count: got %0d want 4", rx_q.size() - base); end
        for (int k = 0; k < 4; k++) begin
            compared++;
            if (rx_at(base + k) !== mk(10 + k)) begin
                failed++; $display("FAIL band_pass_data[%0d]: got %h want %h", k, rx_at(base + k), mk(10 + k));
            end
        end
        repeat (3) sync();
        compared++;
        if (done_total - d0 !== 1) begin failed++; $display("FAIL band_pass_done: got %0d pulses want 1", done_total - d0); end
        compared++;
        if (frame_count_out !== 16'd1 || bins_sent_out !== 11'd4 || length_error_out !== 1'b0) begin
            failed++; $display("FAIL band_pass_stats: cnt=%0d sent=%0d err=%b want 1/4/0",
                               frame_count_out, bins_sent_out, length_error_out);
        end
    endtask

    task automatic test_backpressure();
        int base, d0, st; bit tmo;
        base = rx_q.size(); d0 = done_total;
        bin_lo_in = 10; bin_hi_in = 13; bus.loc_ready_in = 1'b0; enable_in = 1'b1;
        send_beats(0, 9, 1023, st, tmo);
        @(negedge clk_in);
        compared++;
        if (tmo || bus.loc_valid_out !== 1'b0) begin
            failed++; $display("FAIL bp_pre_band: valid=%b tmo=%b want 0/0", bus.loc_valid_out, tmo);
        end
        send_beats(10, 10, 1023, st, tmo);
        @(negedge clk_in);
        compared++;
        if (bus.loc_valid_out !== 1'b1 || bus.loc_data_out !== mk(10)) begin
            failed++; $display("FAIL bp_latency: valid=%b data=%h want 1/%h", bus.loc_valid_out, bus.loc_data_out, mk(10));
        end
        send_beats(11, 1023, 1023, st, tmo);
        compared++;
        if (tmo || st !== 0) begin failed++; $display("FAIL bp_oob_ready: stalls=%0d tmo=%b want 0/0", st, tmo); end
        repeat (5) sync();
        @(negedge clk_in);
        compared++;
        if (frame_active_out !== 1'b1 || bus.fft_ready_out !== 1'b0 || done_total != d0 || rx_q.size() != base) begin
            failed++; $display("FAIL bp_drain_hold: act=%b ready=%b done=%0d rx=%0d want 1/0/0/0",
                               frame_active_out, bus.fft_ready_out, done_total - d0, rx_q.size() - base);
        end
        sync();
        enable_in = 1'b0;
        bus.loc_ready_in = 1'b1;
        wait_done(d0 + 1);
        compared++;
        if (rx_q.size() - base !== 4) begin failed++; $display("FAIL bp_count: got %0d want 4", rx_q.size() - base); end
        for (int k = 0; k < 4; k++) begin
            compared++;
            if (rx_at(base + k) !== mk(10 + k)) begin
                failed++; $display("FAIL bp_data[%0d]: got %h want %h", k, rx_at(base + k), mk(10 + k));
            end
        end
        compared++;
        if (frame_count_out !== 16'd2 || bins_sent_out !== 11'd4 || done_total - d0 !== 1) begin
            failed++; $display("FAIL bp_stats: cnt=%0d sent=%0d done=%0d want 2/4/1",
                               frame_count_out, bins_sent_out, done_total - d0);
        end
    endtask

    task automatic test_empty_band();
        int v0, d0, st; bit tmo;
        d0 = done_total;
        bin_lo_in = 20; bin_hi_in = 5; enable_in = 1'b1;
        v0 = valid_total;
        send_beats(0, 1023, 1023, st, tmo);
        enable_in = 1'b0;
        wait_done(d0 + 1);
        compared++;
        if (tmo || valid_total - v0 !== 0) begin
            failed++; $display("FAIL empty_band_valid: got %0d valid cycles tmo=%b want 0/0", valid_total - v0, tmo);
        end
        compared++;
        if (done_total - d0 !== 1 || frame_count_out !== 16'd3 || bins_sent_out !== 11'd0) begin
            failed++; $display("FAIL empty_band_stats: done=%0d cnt=%0d sent=%0d want 1/3/0",
                               done_total - d0, frame_count_out, bins_sent_out);
        end
    endtask

    task automatic test_short_frame();
        int base, d0, st; bit tmo;
        base = rx_q.size(); d0 = done_total;
        bin_lo_in = 0; bin_hi_in = 3; enable_in = 1'b1;
        send_beats(0, 599, 599, st, tmo);
        wait_done(d0 + 1);
        compared++;
        if (tmo || length_error_out !== 1'b1 || frame_count_out !== 16'd4 || bins_sent_out !== 11'd4) begin
            failed++; $display("FAIL short_stats: err=%b cnt=%0d sent=%0d tmo=%b want 1/4/4/0",
                               length_error_out, frame_count_out, bins_sent_out, tmo);
        end
        base = rx_q.size();
        send_beats(0, 1023, 1023, st, tmo);
        enable_in = 1'b0;
        wait_done(d0 + 2);
        compared++;
        if (tmo || rx_q.size() - base !== 4) begin
            failed++; $display("FAIL short_next_count: got %0d tmo=%b want 4/0", rx_q.size() - base, tmo);
        end
        for (int k = 0; k < 4; k++) begin
            compared++;
            if (rx_at(base + k) !== mk(k)) begin
                failed++; $display("FAIL short_next_data[%0d]: got %h want %h", k, rx_at(base + k), mk(k));
            end
        end
        compared++;
        if (length_error_out !== 1'b1 || frame_count_out !== 16'd5) begin
            failed++; $display("FAIL short_sticky: err=%b cnt=%0d want 1/5", length_error_out, frame_count_out);
        end
    endtask

    task automatic test_enable_drop();
        int base, d0, st, bad; bit tmo, tmo2;
        base = rx_q.size(); d0 = done_total;
        bin_lo_in = 5; bin_hi_in = 6; enable_in = 1'b1;
        send_beats(0, 299, 1023, st, tmo);
        enable_in = 1'b0;
        send_beats(300, 1023, 1023, st, tmo2);
        wait_done(d0 + 1);
        compared++;
        if (tmo || tmo2 || frame_count_out !== 16'd6 || rx_q.size() - base !== 2 ||
            rx_at(base) !== mk(5) || rx_at(base + 1) !== mk(6)) begin
            failed++; $display("FAIL en_drop_frame: cnt=%0d rx=%0d tmo=%b/%b want 6/2/0/0",
                               frame_count_out, rx_q.size() - base, tmo, tmo2);
        end
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_in);
            if (bus.fft_ready_out !== 1'b0 || frame_active_out !== 1'b0) bad++;
        end
        compared++;
        if (bad !== 0) begin failed++; $display("FAIL en_drop_idle: got %0d busy cycles want 0", bad); end
        sync();
        bin_lo_in = 2; bin_hi_in = 3; enable_in = 1'b1;
        repeat (2) sync();
        @(negedge clk_in);
        compared++;
        if (bus.fft_ready_out !== 1'b1 || frame_active_out !== 1'b1) begin
            failed++; $display("FAIL en_restart: ready=%b act=%b want 1/1", bus.fft_ready_out, frame_active_out);
        end
    endtask

    task automatic test_reset_midframe();
        int st; bit tmo;
        bus.loc_ready_in = 1'b0;
        send_beats(0, 3, 1023, st, tmo);
        @(negedge clk_in);
        compared++;
        if (tmo || bus.loc_valid_out !== 1'b1 || bus.loc_data_out !== mk(2)) begin
            failed++; $display("FAIL rst_mid_pre: valid=%b data=%h want 1/%h", bus.loc_valid_out, bus.loc_data_out, mk(2));
        end
        sync();
        rst_n_in = 1'b0;
        #1;
        compared++;
        if (bus.loc_valid_out !== 1'b0 || bus.loc_data_out !== '0 || bus.fft_ready_out !== 1'b0 ||
            frame_active_out !== 1'b0 || frame_count_out !== 16'd0 || length_error_out !== 1'b0 ||
            bins_sent_out !== '0) begin
            failed++; $display("FAIL rst_mid_async: valid=%b ready=%b act=%b cnt=%0d err=%b sent=%0d want all 0",
                               bus.loc_valid_out, bus.fft_ready_out, frame_active_out, frame_count_out,
                               length_error_out, bins_sent_out);
        end
        enable_in = 1'b0;
        bus.loc_ready_in = 1'b1;
        repeat (2) sync();
        rst_n_in = 1'b1;
        repeat (4) sync();
        @(negedge clk_in);
        compared++;
        if (bus.loc_valid_out !== 1'b0 || frame_count_out !== 16'd0 || bus.fft_ready_out !== 1'b0) begin
            failed++; $display("FAIL rst_mid_after: valid=%b cnt=%0d ready=%b want 0/0/0",
                               bus.loc_valid_out, frame_count_out, bus.fft_ready_out);
        end
    endtask

    task automatic test_long_frame();
        int base, d0, st; bit tmo;
        base = rx_q.size(); d0 = done_total;
        bin_lo_in = 1023; bin_hi_in = 1023; enable_in = 1'b1;
        send_beats(0, 1025, 1025, st, tmo);
        enable_in = 1'b0;
        wait_done(d0 + 1);
        compared++;
        if (tmo || rx_q.size() - base !== 3 || rx_at(base) !== mk(1023) || rx_at(base + 2) !== mk(1025)) begin
            failed++; $display("FAIL long_data: rx=%0d first=%h tmo=%b want 3/%h/0",
                               rx_q.size() - base, rx_at(base), tmo, mk(1023));
        end
        compared++;
        if (bins_sent_out !== 11'd3 || length_error_out !== 1'b1 || frame_count_out !== 16'd1) begin
            failed++; $display("FAIL long_stats: sent=%0d err=%b cnt=%0d want 3/1/1",
                               bins_sent_out, length_error_out, frame_count_out);
        end
    endtask

    initial begin
        test_reset();
        test_band_pass();
        test_backpressure();
        test_empty_band();
        test_short_frame();
        test_enable_drop();
        test_reset_midframe();
        test_long_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end
endmodule
